// File: rtl/spectro_frame_receiver.sv
// Receive-side deserializer for the spectrogram serial link: rebuilds 16 x 12-bit
// words per frame and publishes each completed frame into a read buffer with ready/ack.
module spectro_frame_receiver #(
  parameter int WORD_W  = 12,
  parameter int N_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sl_in,
  input  logic              frame_start,
  output logic              word_valid,
  output logic [3:0]        word_idx,
  output logic [WORD_W-1:0] word_data,
  input  logic [3:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              overrun,
  output logic              framing_err,
  input  logic              err_clear
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX    = 4'(N_WORDS - 1);
  localparam logic [3:0] LAST_BIT_M1 = 4'(WORD_W - 1);

  state_t              state_q, state_d;
  logic                frame_start_q;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic                word_valid_q, word_valid_d;
  logic [3:0]          word_idx_q, word_idx_d;
  logic [WORD_W-1:0]   word_data_q, word_data_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                frame_ready_q, frame_ready_d;
  logic                overrun_q, overrun_d;
  logic                framing_err_q, framing_err_d;
  logic [WORD_W-1:0]   capture_q [N_WORDS];
  logic [WORD_W-1:0]   capture_d [N_WORDS];
  logic [WORD_W-1:0]   publish_q [N_WORDS];
  logic [WORD_W-1:0]   publish_d [N_WORDS];

  logic                fs_rise_s;
  logic                ack_s;
  logic                set_ovr_s;
  logic                set_ferr_s;
  logic [WORD_W-1:0]   shift_word_s;

  // Next-state, datapath and error-flag computation.
  always_comb begin
    fs_rise_s     = frame_start & ~frame_start_q;
    ack_s         = frame_ack & frame_ready_q;
    shift_word_s  = {shreg_q[WORD_W-2:0], serial_in};
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    idx_d         = idx_q;
    word_valid_d  = 1'b0;
    word_idx_d    = word_idx_q;
    word_data_d   = word_data_q;
    capture_d     = capture_q;
    publish_d     = publish_q;
    set_ovr_s     = 1'b0;
    set_ferr_s    = 1'b0;
    rd_data_d     = publish_q[rd_addr];
    // The ack is applied first so a same-cycle DONE can republish cleanly.
    frame_ready_d = ack_s ? 1'b0 : frame_ready_q;

    if (fs_rise_s && (state_q != IDLE) && (state_q != ARM)) begin
      state_d   = ARM;
      idx_d     = 4'd0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fs_rise_s) begin
            state_d   = ARM;
            idx_d     = 4'd0;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
        ARM: begin
          idx_d     = 4'd0;
          bit_cnt_d = 4'd0;
          if (sl_in) begin
            state_d = LOAD;
          end else begin
            state_d = ARM;
          end
        end
        LOAD: begin
          if (!sl_in) begin
            shreg_d   = shift_word_s;
            bit_cnt_d = 4'd1;
            state_d   = SHIFT;
          end else begin
            state_d = LOAD;
          end
        end
        SHIFT: begin
          if (!sl_in) begin
            shreg_d   = shift_word_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT_M1) begin
              state_d            = HOLD;
              word_valid_d       = 1'b1;
              word_idx_d         = idx_q;
              word_data_d        = shift_word_s;
              capture_d[idx_q]   = shift_word_s;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            set_ferr_s = 1'b1;
            bit_cnt_d  = 4'd0;
            state_d    = LOAD;
          end
        end
        HOLD: begin
          if (sl_in) begin
            bit_cnt_d = 4'd0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = LOAD;
            end
          end else begin
            set_ferr_s = 1'b1;
            state_d    = HOLD;
          end
        end
        DONE: begin
          if (frame_ready_q && !frame_ack) begin
            set_ovr_s = 1'b1;
          end else begin
            publish_d     = capture_q;
            frame_ready_d = 1'b1;
          end
          idx_d   = 4'd0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A same-cycle error event outranks err_clear.
    overrun_d     = set_ovr_s  | (overrun_q     & ~err_clear);
    framing_err_d = set_ferr_s | (framing_err_q & ~err_clear);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_start_q <= 1'b0;
      shreg_q       <= {WORD_W{1'b0}};
      bit_cnt_q     <= 4'd0;
      idx_q         <= 4'd0;
      word_valid_q  <= 1'b0;
      word_idx_q    <= 4'd0;
      word_data_q   <= {WORD_W{1'b0}};
      rd_data_q     <= {WORD_W{1'b0}};
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) begin
        capture_q[i] <= {WORD_W{1'b0}};
        publish_q[i] <= {WORD_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      frame_start_q <= frame_start;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_q         <= idx_d;
      word_valid_q  <= word_valid_d;
      word_idx_q    <= word_idx_d;
      word_data_q   <= word_data_d;
      rd_data_q     <= rd_data_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
      framing_err_q <= framing_err_d;
      capture_q     <= capture_d;
      publish_q     <= publish_d;
    end
  end

  assign word_valid  = word_valid_q;
  assign word_idx    = word_idx_q;
  assign word_data   = word_data_q;
  assign rd_data     = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign overrun     = overrun_q;
  assign framing_err = framing_err_q;

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Directed self-checking bench for spectro_frame_receiver: one task per scenario,
// word_valid pulses collected by a negedge monitor.
module tb_spectro_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_in;
  logic        sl_in;
  logic        frame_start;
  logic        word_valid;
  logic [3:0]  word_idx;
  logic [11:0] word_data;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic        frame_ready;
  logic        frame_ack;
  logic        overrun;
  logic        framing_err;
  logic        err_clear;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  mon_idx [$];
  logic [11:0] mon_data [$];

  spectro_frame_receiver #(.WORD_W(12), .N_WORDS(16)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .sl_in(sl_in),
    .frame_start(frame_start), .word_valid(word_valid), .word_idx(word_idx),
    .word_data(word_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .overrun(overrun),
    .framing_err(framing_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) begin
      mon_idx.push_back(word_idx);
      mon_data.push_back(word_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_idx.delete();
    mon_data.delete();
  endtask

  task automatic frame_sync();
    frame_start = 1'b1;
    sl_in       = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
  endtask

  task automatic send_word(input logic [11:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sl_in     = 1'b0;
      serial_in = w[11-i];
      tick(1);
    end
    sl_in     = 1'b1;
    serial_in = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input logic [11:0] base);
    for (int k = 0; k < 16; k++) send_word(base + 12'(k), 12);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  task automatic read_addr(input logic [3:0] a);
    rd_addr = a;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_checks++;
    if ({word_valid, word_idx, word_data, rd_data, frame_ready, overrun, framing_err} !== 31'd0) begin
      $display("FAIL reset_outputs got wv=%0b idx=%0d data=%h rd=%h rdy=%0b ovr=%0b ferr=%0b exp all 0",
               word_valid, word_idx, word_data, rd_data, frame_ready, overrun, framing_err);
    end else n_pass++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_nominal();
    clear_mon();
    frame_sync();
    send_frame(12'h100);
    tick(2);
    n_checks++;
    if (mon_idx.size() !== 16) $display("FAIL nominal_count got %0d exp 16", mon_idx.size());
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      if (k < mon_idx.size()) begin
        n_checks++;
        if (mon_idx[k] !== 4'(k) || mon_data[k] !== 12'h100 + 12'(k))
          $display("FAIL nominal_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   k, mon_idx[k], mon_data[k], k, 12'h100 + 12'(k));
        else n_pass++;
      end
    end
    n_checks++;
    if (frame_ready !== 1'b1 || overrun !== 1'b0 || framing_err !== 1'b0)
      $display("FAIL nominal_flags got rdy=%0b ovr=%0b ferr=%0b exp 1 0 0", frame_ready, overrun, framing_err);
    else n_pass++;
    read_addr(4'd5);
    n_checks++;
    if (rd_data !== 12'h105) $display("FAIL nominal_rd5 got %h exp 105", rd_data);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (frame_ready !== 1'b0) $display("FAIL nominal_ack got rdy=%0b exp 0", frame_ready);
    else n_pass++;
  endtask

  task automatic test_msb_order();
    logic [11:0] pat;
    pat = 12'b1010_0000_0011;
    clear_mon();
    frame_sync();
    send_word(pat, 12);
    n_checks++;
    if (mon_idx.size() !== 1 || mon_idx[0] !== 4'd0 || mon_data[0] !== 12'hA03)
      $display("FAIL msb_order got n=%0d idx=%0d data=%h exp n=1 idx=0 data=a03",
               mon_idx.size(), mon_idx[0], mon_data[0]);
    else n_pass++;
  endtask

  task automatic test_short_word();
    clear_mon();
    frame_sync();
    for (int k = 0; k < 3; k++) send_word(12'h200 + 12'(k), 12);
    send_word(12'h203, 7);
    n_checks++;
    if (framing_err !== 1'b1 || mon_idx.size() !== 3)
      $display("FAIL short_detect got ferr=%0b n=%0d exp ferr=1 n=3", framing_err, mon_idx.size());
    else n_pass++;
    for (int k = 3; k < 16; k++) send_word(12'h300 + 12'(k), 12);
    tick(2);
    n_checks++;
    if (mon_idx.size() !== 16 || mon_idx[3] !== 4'd3 || mon_data[3] !== 12'h303)
      $display("FAIL short_next got n=%0d idx=%0d data=%h exp n=16 idx=3 data=303",
               mon_idx.size(), mon_idx[3], mon_data[3]);
    else n_pass++;
    read_addr(4'd3);
    n_checks++;
    if (frame_ready !== 1'b1 || rd_data !== 12'h303)
      $display("FAIL short_publish got rdy=%0b rd=%h exp 1 303", frame_ready, rd_data);
    else n_pass++;
    pulse_err_clear();
    n_checks++;
    if (framing_err !== 1'b0) $display("FAIL short_clear got ferr=%0b exp 0", framing_err);
    else n_pass++;
    pulse_ack();
  endtask

  task automatic test_overrun();
    frame_sync();
    send_frame(12'h400);
    tick(2);
    frame_sync();
    send_frame(12'h500);
    tick(2);
    read_addr(4'd2);
    n_checks++;
    if (overrun !== 1'b1 || frame_ready !== 1'b1 || rd_data !== 12'h402)
      $display("FAIL overrun_b got ovr=%0b rdy=%0b rd=%h exp 1 1 402", overrun, frame_ready, rd_data);
    else n_pass++;
    pulse_ack();
    frame_sync();
    send_frame(12'h600);
    tick(2);
    read_addr(4'd2);
    n_checks++;
    if (overrun !== 1'b1 || frame_ready !== 1'b1 || rd_data !== 12'h602)
      $display("FAIL overrun_c got ovr=%0b rdy=%0b rd=%h exp 1 1 602", overrun, frame_ready, rd_data);
    else n_pass++;
    pulse_err_clear();
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear got ovr=%0b exp 0", overrun);
    else n_pass++;
    // Ack lands in the DONE cycle of frame D.
    frame_sync();
    send_frame(12'h700);
    pulse_ack();
    read_addr(4'd2);
    n_checks++;
    if (overrun !== 1'b0 || frame_ready !== 1'b1 || rd_data !== 12'h702)
      $display("FAIL ack_done got ovr=%0b rdy=%0b rd=%h exp 0 1 702", overrun, frame_ready, rd_data);
    else n_pass++;
    pulse_ack();
  endtask

  task automatic test_resync();
    frame_sync();
    for (int k = 0; k < 9; k++) send_word(12'h800 + 12'(k), 12);
    for (int i = 0; i < 5; i++) begin
      sl_in     = 1'b0;
      serial_in = i[0];
      tick(1);
    end
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    sl_in       = 1'b1;
    tick(1);
    clear_mon();
    send_frame(12'h900);
    tick(2);
    n_checks++;
    if (mon_idx.size() !== 16 || mon_idx[0] !== 4'd0 || mon_data[0] !== 12'h900)
      $display("FAIL resync_first got n=%0d idx=%0d data=%h exp n=16 idx=0 data=900",
               mon_idx.size(), mon_idx[0], mon_data[0]);
    else n_pass++;
    read_addr(4'd15);
    n_checks++;
    if (frame_ready !== 1'b1 || framing_err !== 1'b0 || rd_data !== 12'h90F)
      $display("FAIL resync_frame got rdy=%0b ferr=%0b rd=%h exp 1 0 90f", frame_ready, framing_err, rd_data);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    frame_sync();
    for (int k = 0; k < 7; k++) send_word(12'hB00 + 12'(k), 12);
    for (int i = 0; i < 5; i++) begin
      sl_in     = 1'b0;
      serial_in = 1'b1;
      tick(1);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({word_valid, word_idx, word_data, rd_data, frame_ready, overrun, framing_err} !== 31'd0)
      $display("FAIL async_reset got wv=%0b idx=%0d data=%h rd=%h rdy=%0b ovr=%0b ferr=%0b exp all 0",
               word_valid, word_idx, word_data, rd_data, frame_ready, overrun, framing_err);
    else n_pass++;
    tick(2);
    reset = 1'b0;
    sl_in = 1'b1;
    tick(1);
    clear_mon();
    for (int k = 0; k < 3; k++) send_word(12'hC00 + 12'(k), 12);
    read_addr(4'd4);
    n_checks++;
    if (mon_idx.size() !== 0 || rd_data !== 12'h000)
      $display("FAIL async_ignored got n=%0d rd=%h exp n=0 rd=000", mon_idx.size(), rd_data);
    else n_pass++;
    frame_sync();
    send_frame(12'hA00);
    tick(2);
    read_addr(4'd4);
    n_checks++;
    if (mon_idx.size() !== 16 || frame_ready !== 1'b1 || rd_data !== 12'hA04)
      $display("FAIL async_recover got n=%0d rdy=%0b rd=%h exp 16 1 a04", mon_idx.size(), frame_ready, rd_data);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    serial_in   = 1'b0;
    sl_in       = 1'b1;
    frame_start = 1'b0;
    rd_addr     = 4'd0;
    frame_ack   = 1'b0;
    err_clear   = 1'b0;
    test_reset();
    test_nominal();
    test_msb_order();
    test_short_word();
    test_overrun();
    test_resync();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
